// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: FSM states and requester ids.
package dmem_arbiter_pkg;

   typedef enum logic {
      ST_RR   = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   typedef enum logic {
      ARB_CPU = 1'b0,
      ARB_DMA = 1'b1
   } arb_id_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin pick: the requester not named in `last`
// wins a contested cycle; a lone requester always wins.
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic cpu_req,
   input  logic dma_req,
   input  logic last,
   output logic cpu_pick,
   output logic dma_pick
);

   assign cpu_pick = cpu_req & (~dma_req | (last == logic'(ARB_DMA)));
   assign dma_pick = dma_req & (~cpu_req | (last == logic'(ARB_CPU)));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU and a DMA/debug port, with
// round-robin on contention and bounded DMA lock bursts.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   input  logic          dma_req,
   input  logic          dma_lock,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t    state_reg;
   arb_id_t       last_reg;
   logic [CW-1:0] burst_cnt_reg;
   logic [CW-1:0] burst_cnt_next;

   logic locked_grant;
   logic burst_done;
   logic rr_last;
   logic cpu_pick;
   logic dma_pick;

   // A lock that is dropped (or a DMA that stops requesting) falls back to
   // round-robin in the same cycle, with DMA treated as the last winner.
   assign locked_grant   = (state_reg == ST_LOCK) & dma_req & dma_lock;
   assign rr_last        = (state_reg == ST_LOCK) ? logic'(ARB_DMA) : logic'(last_reg);
   assign burst_cnt_next = burst_cnt_reg + 1'b1;
   assign burst_done     = (burst_cnt_next == CW'(MAX_BURST));

   rr_arb2 u_rr (
      .cpu_req  (cpu_req),
      .dma_req  (dma_req),
      .last     (rr_last),
      .cpu_pick (cpu_pick),
      .dma_pick (dma_pick)
   );

   assign dma_gnt   = locked_grant | dma_pick;
   assign cpu_gnt   = ~locked_grant & cpu_pick;
   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign ram_en    = cpu_gnt | dma_gnt;
   assign rdata     = ram_rdata;

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (cpu_gnt) begin
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (dma_gnt) begin
         ram_we    = dma_we;
         ram_addr  = dma_addr;
         ram_wdata = dma_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_RR;
         last_reg      <= ARB_DMA;
         burst_cnt_reg <= '0;
         cpu_rvalid    <= 1'b0;
         dma_rvalid    <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_gnt & ~cpu_we;
         dma_rvalid <= dma_gnt & ~dma_we;
         if (locked_grant) begin
            last_reg <= ARB_DMA;
            if (burst_done) begin
               state_reg     <= ST_RR;
               burst_cnt_reg <= '0;
            end else begin
               burst_cnt_reg <= burst_cnt_next;
            end
         end else begin
            state_reg     <= ST_RR;
            burst_cnt_reg <= '0;
            if (cpu_gnt) begin
               last_reg <= ARB_CPU;
            end else if (dma_gnt) begin
               last_reg <= ARB_DMA;
               // The round-robin grant itself is burst beat 1.
               if (dma_lock && (MAX_BURST > 1)) begin
                  state_reg     <= ST_LOCK;
                  burst_cnt_reg <= CW'(1);
               end
            end else if (state_reg == ST_LOCK) begin
               last_reg <= ARB_DMA;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req, cpu_we;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       cpu_gnt, cpu_stall, cpu_rvalid;
   logic       dma_req, dma_lock, dma_we;
   logic [7:0] dma_addr, dma_wdata;
   logic       dma_gnt, dma_rvalid;
   logic [7:0] rdata;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   logic [7:0] mem [0:255];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DW(8), .AW(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
   endtask

   initial begin
      rst = 0;
      idle();
      // Reset with both requesting reads
      cpu_req = 1; dma_req = 1;
      cyc();
      chk("rst1_cpu_rvalid", 16'(cpu_rvalid), 16'd0);
      chk("rst1_dma_rvalid", 16'(dma_rvalid), 16'd0);
      cyc();
      chk("rst2_cpu_rvalid", 16'(cpu_rvalid), 16'd0);
      chk("rst2_dma_rvalid", 16'(dma_rvalid), 16'd0);
      rst = 1; #1;
      chk("rst_first_cpu_gnt", 16'(cpu_gnt), 16'd1);
      chk("rst_first_dma_gnt", 16'(dma_gnt), 16'd0);
      cyc(); idle(); #1;
      chk("idle_ram_en", 16'(ram_en), 16'd0);
      chk("idle_ram_addr", 16'(ram_addr), 16'd0);
      chk("idle_gnts", 16'({cpu_gnt, dma_gnt}), 16'd0);

      // CPU-only write then read
      cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hAE; #1;
      $display("txn cpu write addr=10 data=ae");
      chk("cpu_wr_gnt", 16'(cpu_gnt), 16'd1);
      chk("cpu_wr_stall", 16'(cpu_stall), 16'd0);
      chk("cpu_wr_ram_we", 16'(ram_we), 16'd1);
      chk("cpu_wr_ram_addr", 16'(ram_addr), 16'h10);
      chk("cpu_wr_ram_wdata", 16'(ram_wdata), 16'hAE);
      cyc(); cpu_we = 0; #1;
      $display("txn cpu read addr=10");
      chk("cpu_rd_gnt", 16'(cpu_gnt), 16'd1);
      chk("cpu_wr_no_rvalid", 16'(cpu_rvalid), 16'd0);
      chk("cpu_rd_ram_we", 16'(ram_we), 16'd0);
      cyc(); idle(); #1;
      chk("cpu_rd_rvalid", 16'(cpu_rvalid), 16'd1);
      chk("cpu_rd_rdata", 16'(rdata), 16'hAE);

      // DMA-only write, leaves last=DMA
      cyc(); dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'h5B; #1;
      $display("txn dma write addr=20 data=5b");
      chk("dma_wr_gnt", 16'(dma_gnt), 16'd1);
      chk("dma_wr_ram_wdata", 16'(ram_wdata), 16'h5B);

      // Continuous contention without lock: CPU,DMA,CPU,DMA
      cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; dma_we = 0; dma_addr = 8'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         $display("txn contend cycle=%0d cpu_gnt=%0b dma_gnt=%0b", i, cpu_gnt, dma_gnt);
         chk($sformatf("rr_cpu_gnt_%0d", i), 16'(cpu_gnt), 16'((i % 2) == 0));
         chk($sformatf("rr_dma_gnt_%0d", i), 16'(dma_gnt), 16'((i % 2) == 1));
         chk($sformatf("rr_stall_%0d", i), 16'(cpu_stall), 16'((i % 2) == 1));
         if (i == 1) begin
            chk("rr_cpu_rvalid", 16'(cpu_rvalid), 16'd1);
            chk("rr_cpu_rdata", 16'(rdata), 16'hAE);
         end
         if (i == 2) begin
            chk("rr_dma_rvalid", 16'(dma_rvalid), 16'd1);
            chk("rr_dma_rdata", 16'(rdata), 16'h5B);
         end
         cyc();
      end
      dma_req = 0; #1;
      chk("cpu_alone_gnt", 16'(cpu_gnt), 16'd1);

      // Locked DMA write burst from last=CPU: 4 DMA grants then CPU
      cyc(); dma_req = 1; dma_lock = 1; dma_we = 1;
      for (int k = 0; k < 5; k++) begin
         dma_addr = 8'(8'h30 + k); dma_wdata = 8'(8'h60 + k); #1;
         $display("txn lock beat=%0d cpu_gnt=%0b dma_gnt=%0b", k, cpu_gnt, dma_gnt);
         chk($sformatf("lock_dma_gnt_%0d", k), 16'(dma_gnt), 16'(k < 4));
         chk($sformatf("lock_cpu_gnt_%0d", k), 16'(cpu_gnt), 16'(k >= 4));
         chk($sformatf("lock_stall_%0d", k), 16'(cpu_stall), 16'(k < 4));
         cyc();
      end

      // Relock, then drop lock after 2 DMA grants
      dma_we = 0; dma_addr = 8'h20; #1;
      chk("drop_dma_gnt_1", 16'(dma_gnt), 16'd1);
      cyc(); #1;
      chk("drop_dma_gnt_2", 16'(dma_gnt), 16'd1);
      cyc(); dma_lock = 0; #1;
      $display("txn lock dropped cpu_gnt=%0b dma_gnt=%0b", cpu_gnt, dma_gnt);
      chk("drop_cpu_gnt", 16'(cpu_gnt), 16'd1);
      chk("drop_dma_gnt_0", 16'(dma_gnt), 16'd0);
      chk("drop_dma_rvalid", 16'(dma_rvalid), 16'd1);
      chk("drop_dma_rdata", 16'(rdata), 16'h5B);
      cyc(); #1;
      chk("after_drop_dma_gnt", 16'(dma_gnt), 16'd1);
      cyc(); #1;
      chk("after_drop_cpu_gnt", 16'(cpu_gnt), 16'd1);

      // Read back a DMA burst write
      cyc(); dma_req = 0; cpu_addr = 8'h32; #1;
      chk("rb_cpu_gnt", 16'(cpu_gnt), 16'd1);
      cyc(); cpu_req = 0; #1;
      $display("txn cpu readback addr=32 data=%0h", rdata);
      chk("rb_rvalid", 16'(cpu_rvalid), 16'd1);
      chk("rb_rdata", 16'(rdata), 16'h62);

      // Reset during beat 2 of a locked DMA read burst
      cyc(); cpu_req = 1; cpu_addr = 8'h10; dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 8'h20; #1;
      chk("mid_burst_gnt_1", 16'(dma_gnt), 16'd1);
      cyc(); rst = 0; #1;
      chk("mid_burst_gnt_2", 16'(dma_gnt), 16'd1);
      cyc();
      chk("mid_rst_dma_rvalid", 16'(dma_rvalid), 16'd0);
      chk("mid_rst_cpu_rvalid", 16'(cpu_rvalid), 16'd0);
      rst = 1; #1;
      $display("txn after reset cpu_gnt=%0b dma_gnt=%0b", cpu_gnt, dma_gnt);
      chk("post_rst_cpu_gnt", 16'(cpu_gnt), 16'd1);
      chk("post_rst_dma_gnt", 16'(dma_gnt), 16'd0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("post_rst_burst_%0d", k), 16'(dma_gnt), 16'd1);
         cyc();
      end
      #1;
      chk("post_rst_burst_end", 16'(cpu_gnt), 16'd1);
      cyc(); idle();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
